cordic_nco_feed: RTL and testbench
==================================

// Module: cordic_nco_feed
// PURPOSE
//  Phase-accumulator source that feeds the CORDIC rotator. Generates (x, y, angle) beats with quadrant pre-folding
//  so the rotator always sees |angle| <= pi/2, inside its convergence range. Output is valid/ready; a burst FSM
//  produces N beats or runs continuously until stopped.
// PARAMETERS
//  DW  10  x/y width, signed Q1.(DW-1)
//  AW  DW  angle width, signed Q1.(AW-1); full scale [-1,1) maps to [-pi,pi)
//  PW  24  phase accumulator width; 2^PW counts are one turn (2*pi); PW > AW
//  CW  16  burst counter width
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset
//  cfg_we     in   1   write pending config (fword/poff/amp)
//  cfg_fword  in   PW  phase increment per beat, unsigned
//  cfg_poff   in   PW  phase offset, added modulo 2^PW
//  cfg_amp    in   DW  start-vector magnitude; MSB ignored, so treated as non-negative
//  start      in   1   begin burst; accepted only in IDLE
//  stop       in   1   end burst early; accepted only in RUN
//  burst_len  in   CW  beats per burst, sampled at start; 0 = continuous
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse at burst end
//  out_valid  out  1   beat valid
//  out_ready  in   1   downstream accepts
//  xout/yout  out  DW  pre-folded start vector, Q1.(DW-1)
//  aout       out  AW  residual angle, Q1.(AW-1), always in [-0.5, 0.5]
// BEHAVIOUR
//  Reset: rst, synchronous, active-high; clock clk. All outputs are 0, state is IDLE, acc = 0, shadow and active
//   config are 0. A reset mid-burst discards the in-flight beat with no done pulse.
//  FSM states: IDLE, RUN, LAST, DONE.
//   IDLE -> RUN on start. acc <= 0, cnt <= burst_len. stop is ignored in IDLE.
//   RUN -> LAST when the final counted beat is loaded, or on stop.
//   LAST -> DONE on the handshake of the pending beat, or immediately if no beat is pending.
//   DONE -> IDLE after 1 cycle with done = 1.
//   start while busy is ignored.
//  Load condition: state == RUN && (!out_valid || out_ready). On load:
//   - the output regs take the beat computed from p = acc + poff_active
//   - acc <= acc + fword_active (wraps modulo 2^PW); cnt decrements when non-zero
//  out_valid: set on load; cleared on a handshake with no simultaneous load.
//   While out_valid && !out_ready, the outputs hold stable.
//   The first beat appears 1 cycle after start is accepted; sustained throughput is 1 beat/clk.
//  Config: cfg_we writes the shadow registers. The shadow is copied to the active registers at start, and at each
//   load after the one in progress. A cfg_we in the same cycle as a load takes effect from the next beat, never
//   mid-beat.
//  Angle: a = p[PW-1 -: AW], truncated (floor), as signed. q = a[AW-1:AW-2].
//   q = 00 or 11: x = amp, y = 0, aout = a
//   q = 01: x = 0, y = amp, aout = a - 0.5 (the 0.5 constant is 2^(AW-2))
//   q = 10: x = 0, y = -amp, aout = a + 0.5
//  Negating amp never overflows because its MSB is forced to 0.
// CONFIGURATION
//  PHASE_DITHER_EN defined: a 16-bit Fibonacci LFSR (taps 16,15,13,4; seed 16'hACE1 on rst) advances on every load.
//   Its low PW-AW bits are added to p before truncation, carry included. The LFSR does not change acc.
//  PHASE_DITHER_EN undefined: plain truncation; no LFSR logic is present.
// STRUCTURE
//  cordic_pkg: DW/AW defaults; typedefs for fixed-point x/y, angle and phase; quadrant enum; FSM state enum;
//   constant ANG_HALF = 2^(AW-2).
//  Sub-module cordic_prerot: combinational quadrant fold from (amp, a) to (x, y, aout). It is reused by the vector
//   path.
// TESTING  (DW = 10, AW = 10, PW = 24, amp = 0x100)
//  fword = 2^22, poff = 0, burst_len = 4, ready = 1 ->
//   (x, y, a) = (256, 0, 0), (0, 256, 0), (0, -256, -256), (256, 0, -256); done pulses the cycle after beat 4.
//  Same stimulus with ready low on beat 2 for 3 cycles -> beat 2 holds stable; the sequence is unchanged;
//   4 handshakes total.
//  burst_len = 0, stop after 10 handshakes -> the pending beat completes, no extra beat loads, done pulses,
//   busy drops.
//  cfg_we with fword = 2^21 in the cycle of beat-2 load -> beat 2 phase uses 2^22 steps; beat 3 phase = beat 2
//   phase + 2^22; beat 4 phase = beat 3 phase + 2^21.
//  rst asserted mid-burst with valid && !ready -> next cycle: out_valid = 0, busy = 0, done = 0, outputs all 0.
//  poff = 2^24 - 1, fword = 0 -> a = -1 (0x3FF), q = 11: x = 256, y = 0, aout = -1.
//   Under PHASE_DITHER_EN, aout wraps to 0 only when the dither carry occurs.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, fixed-point typedefs and enums for the CORDIC NCO feed
package cordic_pkg;

  localparam int DW_DEF = 10;
  localparam int AW_DEF = DW_DEF;
  localparam int PW_DEF = 24;
  localparam int CW_DEF = 16;

  typedef logic signed [DW_DEF-1:0] xy_t;
  typedef logic signed [AW_DEF-1:0] ang_t;
  typedef logic        [PW_DEF-1:0] phase_t;

  typedef enum logic [1:0] {Q_POS = 2'b00, Q_UP = 2'b01, Q_DN = 2'b10, Q_NEG = 2'b11} quad_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;

  // Quarter turn (pi/2) in an angle of width aw, where full scale is [-pi, pi)
  function automatic int ang_half(input int aw);
    return 1 << (aw - 2);
  endfunction

  localparam int ANG_HALF = ang_half(AW_DEF);

endpackage

// File: rtl/cordic_nco_feed_if.sv
// rtl/cordic_nco_feed_if.sv - beat stream from the NCO feed to the CORDIC rotator
interface cordic_nco_feed_if
  import cordic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] xout;
  logic signed [DW-1:0] yout;
  logic signed [AW-1:0] aout;

  modport master (output out_valid, xout, yout, aout, input out_ready);
  modport slave  (input out_valid, xout, yout, aout, output out_ready);
endinterface

// File: rtl/cordic_prerot.sv
// rtl/cordic_prerot.sv - combinational quadrant fold of (amp, angle) into the rotator's convergence range
module cordic_prerot
  import cordic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic        [DW-1:0] amp,
  input  logic signed [AW-1:0] a,
  output logic signed [DW-1:0] x,
  output logic signed [DW-1:0] y,
  output logic signed [AW-1:0] aout
);

  localparam logic signed [AW-1:0] HALF = AW'(ang_half(AW));

  // MSB forced low so negating the magnitude can never overflow
  logic signed [DW-1:0] mag;
  quad_t                q;

  assign mag = {1'b0, amp[DW-2:0]};
  assign q   = quad_t'(a[AW-1:AW-2]);

  always_comb begin
    x    = mag;
    y    = '0;
    aout = a;
    unique case (q)
      Q_UP: begin
        x    = '0;
        y    = mag;
        aout = a - HALF;
      end
      Q_DN: begin
        x    = '0;
        y    = -mag;
        aout = a + HALF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cordic_nco_feed.sv
// rtl/cordic_nco_feed.sv - burst phase-accumulator source of pre-folded (x, y, angle) beats
// Optional PHASE_DITHER_EN adds LFSR dither below the angle LSB before truncation.
module cordic_nco_feed
  import cordic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_fword,
  input  logic [PW-1:0] cfg_poff,
  input  logic [DW-1:0] cfg_amp,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] burst_len,
  output logic          busy,
  output logic          done,
  cordic_nco_feed_if.master m
);

  state_t               state;
  logic [PW-1:0]        acc, p, pd;
  logic [PW-1:0]        fword_sh, poff_sh, fword_act, poff_act, fword_nx, poff_nx;
  logic [DW-1:0]        amp_sh, amp_act, amp_nx;
  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] a, a_f;
  logic signed [DW-1:0] x_f, y_f;
  logic                 load, hs;

  assign hs   = m.out_valid && m.out_ready;
  assign load = (state == S_RUN) && (!m.out_valid || m.out_ready);

  // Active config takes the shadow including a same-cycle write, so that write lands on the next beat
  assign fword_nx = cfg_we ? cfg_fword : fword_sh;
  assign poff_nx  = cfg_we ? cfg_poff  : poff_sh;
  assign amp_nx   = cfg_we ? cfg_amp   : amp_sh;

  assign p = acc + poff_act;

`ifdef PHASE_DITHER_EN
  localparam logic [PW-1:0] DITH_MASK = (PW'(1) << (PW - AW)) - PW'(1);
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else if (load) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  end

  assign pd = p + (PW'(lfsr) & DITH_MASK);
`else
  assign pd = p;
`endif

  assign a = pd[PW-1 -: AW];

  cordic_prerot #(.DW(DW), .AW(AW)) u_prerot (
    .amp  (amp_act),
    .a    (a),
    .x    (x_f),
    .y    (y_f),
    .aout (a_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      fword_sh    <= '0;
      poff_sh     <= '0;
      amp_sh      <= '0;
      fword_act   <= '0;
      poff_act    <= '0;
      amp_act     <= '0;
      m.out_valid <= 1'b0;
      m.xout      <= '0;
      m.yout      <= '0;
      m.aout      <= '0;
    end else begin
      fword_sh <= fword_nx;
      poff_sh  <= poff_nx;
      amp_sh   <= amp_nx;

      if (load) begin
        m.xout      <= x_f;
        m.yout      <= y_f;
        m.aout      <= a_f;
        m.out_valid <= 1'b1;
        acc         <= acc + fword_act;
        if (cnt != '0) cnt <= cnt - CW'(1);
        fword_act   <= fword_nx;
        poff_act    <= poff_nx;
        amp_act     <= amp_nx;
      end else if (hs) begin
        m.out_valid <= 1'b0;
      end

      unique case (state)
        S_IDLE: if (start) begin
          state     <= S_RUN;
          busy      <= 1'b1;
          acc       <= '0;
          cnt       <= burst_len;
          fword_act <= fword_nx;
          poff_act  <= poff_nx;
          amp_act   <= amp_nx;
        end
        // A zero count never reaches 1, so continuous bursts end only on stop
        S_RUN: if (stop || (load && cnt == CW'(1))) state <= S_LAST;
        S_LAST: if (!m.out_valid || hs) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_nco_feed.sv
// tb/tb_cordic_nco_feed.sv - table-driven scoreboard bench for cordic_nco_feed
module tb_cordic_nco_feed;
  import cordic_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cfg_we, start, stop, busy, done;
  logic [23:0] cfg_fword, cfg_poff;
  logic [9:0]  cfg_amp;
  logic [15:0] burst_len;

  always #5 clk = ~clk;

  cordic_nco_feed_if #(.DW(10), .AW(10)) sif ();

  cordic_nco_feed #(.DW(10), .AW(10), .PW(24), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_fword (cfg_fword),
    .cfg_poff  (cfg_poff),
    .cfg_amp   (cfg_amp),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .m         (sif.master)
  );

  typedef struct { int x; int y; int a; } beat_t;
  typedef struct {
    logic [23:0] fword;
    logic [23:0] poff;
    logic [9:0]  amp;
    int          len;
    beat_t       first;
  } vec_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Independent reference: top AW bits of phase as a signed angle, folded by range
  function automatic beat_t model(input logic [23:0] ph, input logic [9:0] amp);
    beat_t b;
    int ai, mg;
    ai = int'(ph[23:14]);
    if (ai >= 512) ai -= 1024;
    mg = int'(amp[8:0]);
    if (ai >= 256)       b = '{0, mg, ai - 256};
    else if (ai < -256)  b = '{0, -mg, ai + 256};
    else                 b = '{mg, 0, ai};
    return b;
  endfunction

  task automatic push_model(input logic [23:0] fw, input logic [23:0] po,
                            input logic [9:0] amp, input int n, input int skip);
    logic [23:0] accm;
    accm = '0;
    for (int k = 0; k < n; k++) begin
      if (k >= skip) sb.push_back(model(accm + po, amp));
      accm = accm + fw;
    end
  endtask

  task automatic set_cfg(input logic [23:0] fw, input logic [23:0] po, input logic [9:0] amp);
    @(negedge clk);
    cfg_we = 1'b1; cfg_fword = fw; cfg_poff = po; cfg_amp = amp;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_burst(input int len, input int exp_hs, input int stall_beat,
                           input bit cfg_mid, input int stop_after);
    int hs_n, stall, cyc, last_hs;
    bit seen_v, stopped, got_done;
    beat_t e;
    hs_n = 0; stall = 0; cyc = 0; last_hs = -10;
    seen_v = 0; stopped = 0; got_done = 0;
    @(negedge clk);
    burst_len = len[15:0]; start = 1'b1; sif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got_done && cyc < 300) begin
      cfg_we = 1'b0; stop = 1'b0; sif.out_ready = 1'b1;
      if (done) begin
        got_done = 1;
        chk("done_latency", cyc - last_hs, 1);
        chk("hs_count", hs_n, exp_hs);
        chk("busy_at_done", int'(busy), 1);
      end else begin
        if (stall_beat >= 0 && hs_n == stall_beat && sif.out_valid && stall < 3) begin
          sif.out_ready = 1'b0;
          stall++;
        end
        if (cfg_mid && sif.out_valid && !seen_v) begin
          cfg_we = 1'b1; cfg_fword = 24'h200000;
        end
        if (stop_after > 0 && hs_n == stop_after && !stopped) begin
          stop = 1'b1; sif.out_ready = 1'b0; stopped = 1;
        end
        if (sif.out_valid) begin
          seen_v = 1;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_beat: got beat %0d want none", hs_n + 1);
          end else begin
            e = sb[0];
            chk("xout", int'($signed(sif.xout)), e.x);
            chk("yout", int'($signed(sif.yout)), e.y);
            chk("aout", int'($signed(sif.aout)), e.a);
            if (sif.out_ready) begin
              void'(sb.pop_front());
              hs_n++;
              last_hs = cyc;
            end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done want done within 300 cycles");
    end
    @(negedge clk);
    chk("done_cleared", int'(done), 0);
    chk("busy_cleared", int'(busy), 0);
    chk("valid_cleared", int'(sif.out_valid), 0);
    sb.delete();
  endtask

  task automatic push_spec(input bit cfg_variant);
    sb.push_back('{256, 0, 0});
    sb.push_back('{0, 256, 0});
    sb.push_back('{0, -256, -256});
    if (cfg_variant) sb.push_back('{0, -256, -128});
    else             sb.push_back('{256, 0, -256});
  endtask

  vec_t vecs[5];

  initial begin
    int w;
    vecs[0] = '{24'h123457, 24'h0ABCDE, 10'h1FF, 7, '{511, 0, 42}};
    vecs[1] = '{24'h000000, 24'hFFFFFF, 10'h100, 1, '{256, 0, -1}};
    vecs[2] = '{24'hF00000, 24'h400000, 10'h3FF, 5, '{0, 511, 0}};
    vecs[3] = '{24'h00C000, 24'h7FC000, 10'h0AB, 6, '{0, 171, 255}};
    vecs[4] = '{24'h800000, 24'h400000, 10'h100, 3, '{0, 256, 0}};

    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_fword = '0; cfg_poff = '0; cfg_amp = '0; burst_len = '0;
    sif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(sif.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(sif.xout), 0);
    chk("rst_y", int'(sif.yout), 0);
    chk("rst_a", int'(sif.aout), 0);
    rst = 1'b0;

    set_cfg(24'h400000, 24'h0, 10'h100);
    push_spec(0);
    run_burst(4, 4, -1, 0, 0);

    set_cfg(24'h400000, 24'h0, 10'h100);
    push_spec(0);
    run_burst(4, 4, 1, 0, 0);

    set_cfg(24'h400000, 24'h0, 10'h100);
    push_spec(1);
    run_burst(4, 4, -1, 1, 0);

    for (int i = 0; i < 5; i++) begin
      set_cfg(vecs[i].fword, vecs[i].poff, vecs[i].amp);
      sb.push_back(vecs[i].first);
      push_model(vecs[i].fword, vecs[i].poff, vecs[i].amp, vecs[i].len, 1);
      run_burst(vecs[i].len, vecs[i].len, (vecs[i].len > 2) ? 2 : -1, 0, 0);
    end

    set_cfg(24'h400000, 24'h0, 10'h100);
    push_model(24'h400000, 24'h0, 10'h100, 16, 0);
    run_burst(0, 11, -1, 0, 10);

    // Reset while a beat is stalled
    set_cfg(24'h400000, 24'h0, 10'h100);
    @(negedge clk);
    burst_len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!sif.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_valid_seen", int'(sif.out_valid), 1);
    sif.out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", int'(sif.out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_x", int'(sif.xout), 0);
    chk("rst_mid_y", int'(sif.yout), 0);
    chk("rst_mid_a", int'(sif.aout), 0);
    rst = 1'b0; sif.out_ready = 1'b1;

    set_cfg(24'h400000, 24'h0, 10'h100);
    push_spec(0);
    run_burst(4, 4, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
